clk_phase_sequencer: RTL and testbench

//   Consumes the divided processor clock and turns each processor cycle into four ordered,
//   non-overlapping phase enables: fetch, regread, exec/mem and writeback.

---
 rtl/clk_phase_sequencer.sv | 103 ++++++++++
 tb/tb_clk_phase_sequencer.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/clk_phase_sequencer.sv
// Turns each processor cycle into four ordered, non-overlapping phase enables
// (fetch, regread, exec/mem, writeback) with run, single-step and stall control.
module clk_phase_sequencer #(
    parameter int PHASE_LEN = 2,
    parameter int CNT_W     = 32
) (
    input  logic             in_clk,
    input  logic             reset,
    input  logic             run,
    input  logic             step,
    input  logic             stall,
    output logic [3:0]       phase,
    output logic             cycle_done,
    output logic             running,
    output logic [CNT_W-1:0] cycle_count
);

    localparam int SUB_W = (PHASE_LEN > 1) ? $clog2(PHASE_LEN) : 1;
    localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(PHASE_LEN - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STEP = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [SUB_W-1:0] sub;
    logic [SUB_W-1:0] sub_next;
    logic [3:0]       phase_next;
    logic             done_next;
    logic             step_q;
    logic             step_rise;
    logic             cycle_end;

    assign step_rise = step & ~step_q;
    assign cycle_end = (state != IDLE) && phase[3] && (sub == SUB_LAST) && !stall;

    always_ff @(posedge in_clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            sub         <= '0;
            phase       <= 4'b0000;
            cycle_done  <= 1'b0;
            running     <= 1'b0;
            cycle_count <= '0;
            step_q      <= 1'b0;
        end else begin
            state      <= state_next;
            sub        <= sub_next;
            phase      <= phase_next;
            cycle_done <= done_next;
            running    <= (state_next != IDLE);
            step_q     <= step;
            if (cycle_end)
                cycle_count <= cycle_count + CNT_W'(1);
        end
    end

    // cycle_done is registered, so it is derived from where the sequencer lands next
    always_comb begin
        state_next = state;
        sub_next   = sub;
        phase_next = phase;
        case (state)
            IDLE: begin
                if (run) begin
                    state_next = RUN;
                    phase_next = 4'b0001;
                    sub_next   = '0;
                end else if (step_rise) begin
                    state_next = STEP;
                    phase_next = 4'b0001;
                    sub_next   = '0;
                end
            end
            default: begin
                if (!stall) begin
                    if (sub != SUB_LAST) begin
                        sub_next = sub + SUB_W'(1);
                    end else begin
                        sub_next = '0;
                        if (phase[3]) begin
                            if (run) begin
                                state_next = RUN;
                                phase_next = 4'b0001;
                            end else begin
                                state_next = IDLE;
                                phase_next = 4'b0000;
                            end
                        end else begin
                            phase_next = phase << 1;
                        end
                    end
                end
            end
        endcase
        done_next = (state_next != IDLE) && phase_next[3] && (sub_next == SUB_LAST)
                    && !(stall && (state != IDLE));
    end

endmodule

// File: tb/tb_clk_phase_sequencer.sv
// Directed bench for clk_phase_sequencer: one PHASE_LEN=2 instance and one
// PHASE_LEN=1, CNT_W=4 instance for the single-cycle phase and wrap cases.
module tb_clk_phase_sequencer;

    logic        in_clk;
    logic        reset;
    logic        run;
    logic        step;
    logic        stall;
    logic [3:0]  phase;
    logic        cycle_done;
    logic        running;
    logic [31:0] cycle_count;

    logic        run2;
    logic        step2;
    logic        stall2;
    logic [3:0]  phase2;
    logic        cycle_done2;
    logic        running2;
    logic [3:0]  cycle_count2;

    int tests;
    int failures;

    clk_phase_sequencer #(.PHASE_LEN(2), .CNT_W(32)) dut (
        .in_clk(in_clk),
        .reset(reset),
        .run(run),
        .step(step),
        .stall(stall),
        .phase(phase),
        .cycle_done(cycle_done),
        .running(running),
        .cycle_count(cycle_count)
    );

    clk_phase_sequencer #(.PHASE_LEN(1), .CNT_W(4)) dut_short (
        .in_clk(in_clk),
        .reset(reset),
        .run(run2),
        .step(step2),
        .stall(stall2),
        .phase(phase2),
        .cycle_done(cycle_done2),
        .running(running2),
        .cycle_count(cycle_count2)
    );

    initial in_clk = 1'b0;
    always #5 in_clk = ~in_clk;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            failures++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic apply_stimulus(input logic r, input logic s, input logic st);
        run   = r;
        step  = s;
        stall = st;
    endtask

    // advance one edge and sample 1 time unit later
    task automatic tick();
        @(posedge in_clk);
        #1;
    endtask

    initial begin
        logic [3:0] exp_ph;
        tests    = 0;
        failures = 0;
        reset    = 1'b0;
        run2     = 1'b0;
        step2    = 1'b0;
        stall2   = 1'b0;
        apply_stimulus(1'b0, 1'b0, 1'b0);

        #2;
        check_output("reset_phase", 32'(phase), 32'h0);
        check_output("reset_done", 32'(cycle_done), 32'h0);
        check_output("reset_running", 32'(running), 32'h0);
        check_output("reset_count", cycle_count, 32'h0);
        check_output("reset_phase2", 32'(phase2), 32'h0);

        @(negedge in_clk);
        reset = 1'b1;

        // free run: three cycles, run dropped during the third
        apply_stimulus(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 24; i++) begin
            tick();
            exp_ph = 4'b0001 << ((i % 8) / 2);
            check_output($sformatf("run_phase_%0d", i), 32'(phase), 32'(exp_ph));
            check_output($sformatf("run_done_%0d", i), 32'(cycle_done), 32'((i % 8) == 7));
            check_output($sformatf("run_count_%0d", i), cycle_count, 32'(i / 8));
            if (i == 16)
                apply_stimulus(1'b0, 1'b0, 1'b0);
        end
        tick();
        check_output("run_end_phase", 32'(phase), 32'h0);
        check_output("run_end_running", 32'(running), 32'h0);
        check_output("run_end_count", cycle_count, 32'd3);
        tick();
        check_output("idle_hold_phase", 32'(phase), 32'h0);

        // single step with a wide step pulse; stall in IDLE is ignored
        apply_stimulus(1'b0, 1'b1, 1'b1);
        tick();
        apply_stimulus(1'b0, 1'b1, 1'b0);
        for (int j = 0; j < 8; j++) begin
            if (j > 0)
                tick();
            exp_ph = 4'b0001 << (j / 2);
            check_output($sformatf("step_phase_%0d", j), 32'(phase), 32'(exp_ph));
            check_output($sformatf("step_done_%0d", j), 32'(cycle_done), 32'(j == 7));
            if (j == 1)
                apply_stimulus(1'b0, 1'b0, 1'b0);
        end
        tick();
        check_output("step_end_phase", 32'(phase), 32'h0);
        check_output("step_end_running", 32'(running), 32'h0);
        check_output("step_end_count", cycle_count, 32'd4);
        tick();
        check_output("step_no_repeat", 32'(phase), 32'h0);

        // run dropped during the first regread cycle; cycle still completes
        apply_stimulus(1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 8; k++) begin
            tick();
            exp_ph = 4'b0001 << (k / 2);
            check_output($sformatf("drop_phase_%0d", k), 32'(phase), 32'(exp_ph));
            if (k == 2)
                apply_stimulus(1'b0, 1'b0, 1'b0);
        end
        check_output("drop_done", 32'(cycle_done), 32'h1);
        tick();
        check_output("drop_end_phase", 32'(phase), 32'h0);
        check_output("drop_end_count", cycle_count, 32'd5);

        // stall for 5 edges from the first exec cycle: 13 in_clk cycle
        apply_stimulus(1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 13; k++) begin
            tick();
            if (k < 2)       exp_ph = 4'b0001;
            else if (k < 4)  exp_ph = 4'b0010;
            else if (k < 11) exp_ph = 4'b0100;
            else             exp_ph = 4'b1000;
            check_output($sformatf("stall_phase_%0d", k), 32'(phase), 32'(exp_ph));
            check_output($sformatf("stall_done_%0d", k), 32'(cycle_done), 32'(k == 12));
            if (k == 4) apply_stimulus(1'b1, 1'b0, 1'b1);
            if (k == 5) apply_stimulus(1'b0, 1'b0, 1'b1);
            if (k == 9) apply_stimulus(1'b0, 1'b0, 1'b0);
        end
        tick();
        check_output("stall_end_phase", 32'(phase), 32'h0);
        check_output("stall_end_count", cycle_count, 32'd6);

        // PHASE_LEN=1, CNT_W=4: 16 processor cycles wrap the count to 0
        run2 = 1'b1;
        for (int m = 0; m < 65; m++) begin
            tick();
            if (m < 4) begin
                exp_ph = 4'b0001 << m;
                check_output($sformatf("short_phase_%0d", m), 32'(phase2), 32'(exp_ph));
                check_output($sformatf("short_done_%0d", m), 32'(cycle_done2), 32'(m == 3));
            end
            if (m == 4)  check_output("short_count_1", 32'(cycle_count2), 32'd1);
            if (m == 60) begin
                check_output("short_count_15", 32'(cycle_count2), 32'd15);
                run2 = 1'b0;
            end
            if (m == 63) check_output("short_last_done", 32'(cycle_done2), 32'h1);
            if (m == 64) begin
                check_output("short_wrap_count", 32'(cycle_count2), 32'h0);
                check_output("short_wrap_running", 32'(running2), 32'h0);
            end
        end

        // asynchronous reset between edges during exec
        apply_stimulus(1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++)
            tick();
        check_output("pre_reset_phase", 32'(phase), 32'h4);
        #2;
        reset = 1'b0;
        #1;
        check_output("async_phase", 32'(phase), 32'h0);
        check_output("async_running", 32'(running), 32'h0);
        check_output("async_count", cycle_count, 32'h0);
        apply_stimulus(1'b0, 1'b0, 1'b0);
        @(negedge in_clk);
        reset = 1'b1;
        tick();
        tick();
        check_output("post_reset_phase", 32'(phase), 32'h0);
        check_output("post_reset_running", 32'(running), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
